// File: rtl/iris_nn_argmax.sv
// Argmax stage for the 4-6-3 Iris network: waits LATENCY cycles after start, captures
// three float outputs, picks the winner in two compare steps. Optional macro: CONFIDENCE_EN.
module iris_nn_argmax #(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8,
  parameter int LATENCY   = 16,
  parameter logic [SIG_WIDTH+EXP_WIDTH:0] CONF_THRESH = 32'h3F000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  input  logic [SIG_WIDTH+EXP_WIDTH:0]   neuron7_output,
  input  logic [SIG_WIDTH+EXP_WIDTH:0]   neuron8_output,
  input  logic [SIG_WIDTH+EXP_WIDTH:0]   neuron9_output,
  output logic                           class_valid,
  input  logic                           class_ready,
  output logic [1:0]                     class_id,
  output logic [SIG_WIDTH+EXP_WIDTH:0]   class_score
);
  localparam int W = SIG_WIDTH + EXP_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CMP1, S_CMP2, S_DONE} state_t;

  state_t         r_state;
  logic [7:0]     r_cnt;
  logic [W-1:0]   r_s7, r_s8, r_s9;
  logic [W-1:0]   r_inc_val;
  logic [1:0]     r_inc_idx;
  logic           r_valid;
  logic [1:0]     r_id;
  logic [W-1:0]   r_score;
  logic [W-1:0]   w_win_val;
  logic [1:0]     w_win_idx;
  logic [1:0]     w_final_id;

  function automatic logic f_is_nan(input logic [W-1:0] v);
    return (&v[W-2:SIG_WIDTH]) && (|v[SIG_WIDTH-1:0]);
  endfunction

  // a strictly greater than b; a non-NaN value always displaces a NaN.
  function automatic logic f_gt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-2:0] a_mag;
    logic [W-2:0] b_mag;
    a_mag = a[W-2:0];
    b_mag = b[W-2:0];
    if (f_is_nan(a)) return 1'b0;
    if (f_is_nan(b)) return 1'b1;
    if (a_mag == '0 && b_mag == '0) return 1'b0;
    if (a[W-1] != b[W-1]) return !a[W-1];
    if (!a[W-1]) return a_mag > b_mag;
    return a_mag < b_mag;
  endfunction

  always_comb begin
    w_win_val = r_inc_val;
    w_win_idx = r_inc_idx;
    if (f_gt(r_s9, r_inc_val)) begin
      w_win_val = r_s9;
      w_win_idx = 2'd2;
    end
  end

`ifdef CONFIDENCE_EN
  assign w_final_id = (f_is_nan(w_win_val) || !f_gt(w_win_val, CONF_THRESH)) ? 2'd3 : w_win_idx;
`else
  logic [W-1:0] w_unused_thresh;
  assign w_unused_thresh = CONF_THRESH;
  assign w_final_id      = w_win_idx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_s7      <= '0;
      r_s8      <= '0;
      r_s9      <= '0;
      r_inc_val <= '0;
      r_inc_idx <= '0;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_score   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt   <= 8'(LATENCY - 1);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_s7    <= neuron7_output;
            r_s8    <= neuron8_output;
            r_s9    <= neuron9_output;
            r_state <= S_CMP1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_CMP1: begin
          if (f_gt(r_s8, r_s7)) begin
            r_inc_val <= r_s8;
            r_inc_idx <= 2'd1;
          end else begin
            r_inc_val <= r_s7;
            r_inc_idx <= 2'd0;
          end
          r_state <= S_CMP2;
        end
        S_CMP2: begin
          r_score <= w_win_val;
          r_id    <= w_final_id;
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (r_valid && class_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign class_valid = r_valid;
  assign class_id    = r_id;
  assign class_score = r_score;
endmodule
